// File: rtl/screen_oled_bridge_pkg.sv
// Shared constants, state encoding and pixel helpers for the framebuffer-to-SSD1306 bridge.
// Framebuffer: 64x32 mono, MSB-left rows. OLED: 128x64, 8 pages of LSB-top column bytes.
package screen_oled_bridge_pkg;

  localparam int          ADDR_W_DEFAULT      = 12;
  localparam logic [11:0] SCREEN_BASE_DEFAULT = 12'h100;

  localparam int SCREEN_W      = 64;
  localparam int SCREEN_H      = 32;
  localparam int BYTES_PER_ROW = SCREEN_W / 8;
  localparam int SCREEN_BYTES  = BYTES_PER_ROW * SCREEN_H;
  localparam int OLED_COLS     = 128;
  localparam int OLED_PAGES    = 8;
  localparam int PAGE_BYTES    = SCREEN_BYTES / OLED_PAGES;
  localparam int LOAD_CYCLES   = PAGE_BYTES + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Each chip row becomes two OLED rows: bit k of the column byte is chip row k>>1.
  function automatic logic [7:0] expand2(input logic [3:0] px);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = px[i / 2];
    end
    return r;
  endfunction

endpackage

// File: rtl/screen_oled_bridge_if.sv
// Memory read port and OLED byte stream of the bridge; master is the bridge side.
interface screen_oled_bridge_if #(
  parameter int ADDR_W = 12
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_rd, mem_addr, out_data, out_valid,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_data, out_valid,
    output mem_data, out_ready
  );

endinterface

// File: rtl/screen_oled_bridge_page_buffer.sv
// Holds the four chip rows (32 bytes) feeding one OLED page and muxes out one
// vertically doubled column byte for chip column rd_x.
module oled_page_buffer
  import screen_oled_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_x,
  output logic [7:0] rd_byte
);

  logic [7:0] line_buf_q [PAGE_BYTES];
  logic [3:0] px;

  // NOTE: plain storage has no reset; every slot is rewritten before EMIT reads it.
  always_ff @(posedge clk) begin
    if (we) begin
      line_buf_q[wr_idx] <= wr_data;
    end
  end

  // Slot index is {row, byte}; the pixel inside the byte is MSB-first.
  always_comb begin
    px = '0;
    for (int r = 0; r < 4; r++) begin
      px[r] = line_buf_q[{2'(r), rd_x[5:3]}][~rd_x[2:0]];
    end
  end

  assign rd_byte = expand2(px);

endmodule

// File: rtl/screen_oled_bridge.sv
// Reads the 64x32 framebuffer one page (4 chip rows) at a time and streams the
// 2x-scaled SSD1306 page image, 1024 column bytes per frame, over valid/ready.
module screen_oled_bridge
  import screen_oled_bridge_pkg::*;
#(
  parameter int              ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] SCREEN_BASE = ADDR_W'(SCREEN_BASE_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  screen_oled_bridge_if.master bus
);

  localparam logic [5:0] RD_COUNT  = 6'(PAGE_BYTES);
  localparam logic [5:0] LAST_LOAD = 6'(LOAD_CYCLES - 1);
  localparam logic [6:0] LAST_COL  = 7'(OLED_COLS - 1);
  localparam logic [2:0] LAST_PAGE = 3'(OLED_PAGES - 1);

  state_e     state_q, state_d;
  logic [2:0] page_q, page_d;
  logic [5:0] load_cnt_q, load_cnt_d;
  logic [6:0] col_q, col_d;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              buf_we;
  logic [4:0]        buf_idx;
  logic [7:0]        col_byte;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      page_q     <= '0;
      load_cnt_q <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      load_cnt_q <= load_cnt_d;
      col_q      <= col_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    load_cnt_d = load_cnt_q;
    col_d      = col_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    buf_we     = 1'b0;
    // Data returned in this cycle belongs to the read issued one cycle earlier.
    buf_idx    = load_cnt_q[4:0] - 5'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          page_d     = '0;
          load_cnt_d = '0;
        end
      end

      ST_LOAD: begin
        busy   = 1'b1;
        mem_rd = (load_cnt_q < RD_COUNT);
        if (mem_rd) begin
          mem_addr = SCREEN_BASE + ADDR_W'({page_q, load_cnt_q[4:0]});
        end
        buf_we = (load_cnt_q != 6'd0);
        if (load_cnt_q == LAST_LOAD) begin
          state_d    = ST_EMIT;
          col_d      = '0;
          load_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + 6'd1;
        end
      end

      ST_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = col_byte;
        if (bus.out_ready) begin
          col_d = col_q + 7'd1;
          if (col_q == LAST_COL) begin
            if (page_q == LAST_PAGE) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_LOAD;
              page_d     = page_q + 3'd1;
              load_cnt_d = '0;
            end
          end
        end
      end

      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  oled_page_buffer u_page_buffer (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (buf_idx),
    .wr_data (bus.mem_data),
    .rd_x    (col_q[6:1]),
    .rd_byte (col_byte)
  );

  assign bus.mem_rd    = mem_rd;
  assign bus.mem_addr  = mem_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

endmodule
